pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline stall/flush controller for the five-stage core. It generates the 6-bit `stall` vector and the jump flush that drive the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences three wait sources: a load-use hazard, a multi-cycle divide with a start/ready handshake, and a bus wait with timeout. It also keeps two CSR-visible event counters.

## Interface
- `ADDR_WIDTH`, 32, width of jump target address
- `TIMEOUT`, 16, maximum MEM_WAIT cycles before bus error (≥2)
- `clk_i`  in  1  clock
- `rst_i`  in  1  asynchronous, active-high reset
- `id_rs1_i`, `id_rs2_i`  in  5 each  source register indices of the instruction in ID
- `id_rs1_re_i`, `id_rs2_re_i`  in  1 each  ID actually reads rs1/rs2
- `ex_inst_is_load_i`  in  1  ID/EX holds a load
- `ex_rd_i`  in  5  destination register held in ID/EX
- `div_req_i`  in  1  level; EX holds a divide awaiting its result
- `div_ready_i`  in  1  pulse; divider result valid
- `mem_req_i`  in  1  level; MEM stage has a bus access
- `mem_ack_i`  in  1  bus access complete this cycle
- `jump_req_i`  in  1  EX resolves a taken jump/branch
- `jump_addr_i`  in  ADDR_WIDTH  jump target
- `stall_o`  out  6  bit i = 1 (STOP) holds stage i: 0 PC, 1 IF/ID, 2 ID, 3 EX, 4 MEM, 5 WB
- `flush_jump_o`  out  1  flush IF/ID and ID/EX
- `jump_o`, `jump_addr_o`  out  1, ADDR_WIDTH  PC redirect
- `div_start_o`  out  1  one-cycle divider start pulse
- `bus_err_o`  out  1  one-cycle bus timeout pulse
- `cnt_stall_o`  out  32  cycles with `stall_o[0]`=1, wraps
- `cnt_flush_o`  out  32  cycles with `flush_jump_o`=1, wraps

## Operation
- FSM states: RUN, DIV_WAIT, MEM_WAIT. Registers: state, 8-bit `wait_cnt`, `bus_err_o`, two counters.
- Outputs other than `bus_err_o` and the counters are combinational (Mealy) from state and inputs.
- Load-use hazard `lu` = `ex_inst_is_load_i` & `ex_rd_i`≠0 & ((`id_rs1_re_i` & `id_rs1_i`==`ex_rd_i`) | (`id_rs2_re_i` & `id_rs2_i`==`ex_rd_i`)).
- RUN, evaluated in priority order:
  1. `mem_req_i` & !`mem_ack_i` & !`bus_err_o`: `stall_o`=6'b011111; next state MEM_WAIT; `wait_cnt`←0.
  2. `div_req_i` & !`div_ready_i`: `stall_o`=6'b001111; `div_start_o`=1; next state DIV_WAIT.
  3. `jump_req_i`: `stall_o`=0; `flush_jump_o`=`jump_o`=1; `jump_addr_o`=`jump_addr_i`. The load-use stall is suppressed because the dependent instruction is flushed.
  4. `lu`: `stall_o`=6'b000111. ID/EX inserts a bubble, so the hazard clears next cycle.
  5. Otherwise `stall_o`=0.
- DIV_WAIT: `stall_o`=6'b001111 until `div_ready_i`. In the ready cycle `stall_o`=0 and next state is RUN. `jump_req_i` and `lu` are ignored while in this state.
- MEM_WAIT: `stall_o`=6'b011111.
  - `mem_ack_i`: `stall_o`=0; next state RUN.
  - Else, if `wait_cnt`==TIMEOUT-1: stall is still asserted this cycle; next state RUN; `bus_err_o`←1 for exactly one cycle.
  - Else `wait_cnt`++.
- In the cycle `bus_err_o`=1, mem-wait detection is masked. MEM treats the access as aborted.
- `jump_o`/`flush_jump_o` are never asserted while `stall_o[3]`=1. A jump in a held EX re-presents itself after release.
- `jump_addr_o` = `jump_addr_i` when `jump_o`=1, else 0.
- `div_start_o` is never asserted outside the RUN→DIV_WAIT transition cycle.

## Timing
- Reset (async, immediate):
  - state=RUN, `wait_cnt`=0, `bus_err_o`=0, both counters 0.
  - While `rst_i`=1, all combinational outputs are forced to 0.
  - Reset mid-wait abandons the wait; the first cycle after reset is RUN.
- Load-use costs exactly 1 stall cycle.
- Divide: if `div_ready_i` arrives k cycles after the start cycle, stall lasts k cycles. The start cycle is stalled; the ready cycle is not.
- Bus wait with no ack: TIMEOUT+1 stalled cycles (entry + TIMEOUT in MEM_WAIT). `bus_err_o` follows in the next cycle.
- `mem_ack_i` in the same cycle as `mem_req_i` in RUN produces no stall.
- Counters update on the clock edge ending a cycle in which their condition held.

## Test plan
- Load-use: `ex_inst_is_load_i`=1, `ex_rd_i`=5, `id_rs1_i`=5, `id_rs1_re_i`=1 for one cycle -> `stall_o`=000111 for 1 cycle; `cnt_stall_o`=1. Repeat with `ex_rd_i`=0 -> no stall.
- Divide: `div_req_i` held; `div_ready_i` pulsed 8 cycles after the start cycle -> one `div_start_o` pulse; `stall_o`=001111 for 8 cycles, 0 in the ready cycle; state returns to RUN.
- Timeout (TIMEOUT=16): `mem_req_i`=1, no ack -> 17 cycles of 011111, then `bus_err_o`=1 for 1 cycle with `stall_o`=0; `cnt_stall_o`=17.
- Jump vs load-use: `jump_req_i`=1, `jump_addr_i`=0x80000040, with `lu` true -> `stall_o`=0, `flush_jump_o`=`jump_o`=1, `jump_addr_o`=0x80000040; `cnt_flush_o`=1.
- Priority: `mem_req_i` and `div_req_i` high together, ack after 3 cycles -> `stall_o`=011111 and no `div_start_o` until ack. The next cycle gives `div_start_o`=1 with 001111.
- Reset mid-DIV_WAIT: assert `rst_i` between clock edges -> `stall_o`=0 immediately; counters 0; no `div_start_o` after release unless `div_req_i` is still high.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if
// Bundles every non-clock, non-reset signal of the pipeline stall/flush
// controller.
//   master modport : pipeline side. Drives the hazard, divide, bus and jump
//                    inputs and receives stall/flush/redirect and counters.
//   slave  modport : the controller itself.
// Signals:
//   id_rs1_i/id_rs2_i, id_rs1_re_i/id_rs2_re_i : source regs of the ID instruction
//   ex_inst_is_load_i, ex_rd_i                 : load and destination held in ID/EX
//   div_req_i, div_ready_i, div_start_o        : divider handshake
//   mem_req_i, mem_ack_i, bus_err_o            : bus wait and timeout
//   jump_req_i, jump_addr_i                    : jump resolved in EX
//   jump_o, jump_addr_o, flush_jump_o          : PC redirect and flush
//   stall_o                                    : per-stage hold vector
//   cnt_stall_o, cnt_flush_o                   : event counters
interface pipe_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [4:0]            id_rs1_i;
   logic [4:0]            id_rs2_i;
   logic                  id_rs1_re_i;
   logic                  id_rs2_re_i;
   logic                  ex_inst_is_load_i;
   logic [4:0]            ex_rd_i;
   logic                  div_req_i;
   logic                  div_ready_i;
   logic                  mem_req_i;
   logic                  mem_ack_i;
   logic                  jump_req_i;
   logic [ADDR_WIDTH-1:0] jump_addr_i;
   logic [5:0]            stall_o;
   logic                  flush_jump_o;
   logic                  jump_o;
   logic [ADDR_WIDTH-1:0] jump_addr_o;
   logic                  div_start_o;
   logic                  bus_err_o;
   logic [31:0]           cnt_stall_o;
   logic [31:0]           cnt_flush_o;

   modport master (
      output id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
             ex_inst_is_load_i, ex_rd_i, div_req_i, div_ready_i,
             mem_req_i, mem_ack_i, jump_req_i, jump_addr_i,
      input  stall_o, flush_jump_o, jump_o, jump_addr_o, div_start_o,
             bus_err_o, cnt_stall_o, cnt_flush_o
   );

   modport slave (
      input  id_rs1_i, id_rs2_i, id_rs1_re_i, id_rs2_re_i,
             ex_inst_is_load_i, ex_rd_i, div_req_i, div_ready_i,
             mem_req_i, mem_ack_i, jump_req_i, jump_addr_i,
      output stall_o, flush_jump_o, jump_o, jump_addr_o, div_start_o,
             bus_err_o, cnt_stall_o, cnt_flush_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Stall/flush controller for the five-stage core. It sequences a load-use
// hazard, a multi-cycle divide and a bus wait with timeout. It drives the
// 6-bit stall vector (0 PC, 1 IF/ID, 2 ID, 3 EX, 4 MEM, 5 WB) and the jump
// redirect/flush, and it counts stalled and flushed cycles.
// Ports:
//   clk_i : clock
//   rst_i : asynchronous active-high reset
//   bus   : pipe_ctrl_if slave modport (all handshake/bus signals)
module pipe_ctrl #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {RUN, DIV_WAIT, MEM_WAIT} state_t;

   state_t                state;
   state_t                next_state;
   logic [7:0]            wait_cnt;
   logic                  bus_err;
   logic [31:0]           cnt_stall;
   logic [31:0]           cnt_flush;

   logic                  lu;
   logic [5:0]            stall;
   logic                  flush;
   logic [ADDR_WIDTH-1:0] jump_addr;
   logic                  div_start;
   logic                  set_err;
   logic                  clr_cnt;
   logic                  inc_cnt;

   // Mealy decode of stall/redirect. Priority in RUN is bus wait, then
   // divide, then jump, then load-use. A taken jump hides the load-use
   // stall because the dependent instruction is being flushed anyway.
   // While reset is high every combinational output is held at zero.
   always_comb begin
      lu = bus.ex_inst_is_load_i && (bus.ex_rd_i != 5'd0) &&
           ((bus.id_rs1_re_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
            (bus.id_rs2_re_i && (bus.id_rs2_i == bus.ex_rd_i)));
      stall      = 6'b000000;
      flush      = 1'b0;
      jump_addr  = {ADDR_WIDTH{1'b0}};
      div_start  = 1'b0;
      next_state = state;
      set_err    = 1'b0;
      clr_cnt    = 1'b0;
      inc_cnt    = 1'b0;
      if (!rst_i) begin
         case (state)
            RUN: begin
               // In the bus_err cycle MEM has aborted the access, so a
               // still-high mem_req must not start another wait.
               if (bus.mem_req_i && !bus.mem_ack_i && !bus_err) begin
                  stall      = 6'b011111;
                  next_state = MEM_WAIT;
                  clr_cnt    = 1'b1;
               end else if (bus.div_req_i && !bus.div_ready_i) begin
                  stall      = 6'b001111;
                  div_start  = 1'b1;
                  next_state = DIV_WAIT;
               end else if (bus.jump_req_i) begin
                  flush     = 1'b1;
                  jump_addr = bus.jump_addr_i;
               end else if (lu) begin
                  stall = 6'b000111;
               end
            end
            DIV_WAIT: begin
               if (bus.div_ready_i) begin
                  next_state = RUN;
               end else begin
                  stall = 6'b001111;
               end
            end
            MEM_WAIT: begin
               if (bus.mem_ack_i) begin
                  next_state = RUN;
               end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                  stall      = 6'b011111;
                  next_state = RUN;
                  set_err    = 1'b1;
               end else begin
                  stall   = 6'b011111;
                  inc_cnt = 1'b1;
               end
            end
            default: next_state = RUN;
         endcase
      end
   end

   // State, wait counter, one-cycle bus error pulse and event counters.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         bus_err   <= 1'b0;
         cnt_stall <= 32'd0;
         cnt_flush <= 32'd0;
      end else begin
         state   <= next_state;
         bus_err <= set_err;
         if (clr_cnt) begin
            wait_cnt <= 8'd0;
         end else if (inc_cnt) begin
            wait_cnt <= wait_cnt + 8'd1;
         end
         if (stall[0]) begin
            cnt_stall <= cnt_stall + 32'd1;
         end
         if (flush) begin
            cnt_flush <= cnt_flush + 32'd1;
         end
      end
   end

   assign bus.stall_o      = stall;
   assign bus.flush_jump_o = flush;
   assign bus.jump_o       = flush;
   assign bus.jump_addr_o  = jump_addr;
   assign bus.div_start_o  = div_start;
   assign bus.bus_err_o    = bus_err;
   assign bus.cnt_stall_o  = cnt_stall;
   assign bus.cnt_flush_o  = cnt_flush;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl. A table of single-cycle RUN-state
// vectors covers the hazard/priority decode. Hand-written sequences cover
// the divide wait, the bus timeout, bus-over-divide priority and reset
// in the middle of a divide.
module tb_pipe_ctrl;

   logic clk;
   logic rst;
   int   passed;
   int   total;
   int   exp_stall_cnt;
   int   exp_flush_cnt;

   pipe_ctrl_if #(.ADDR_WIDTH(32)) pif();

   pipe_ctrl #(.ADDR_WIDTH(32), .TIMEOUT(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (pif.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic        load;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        re1;
      logic        re2;
      logic        div_req;
      logic        div_ready;
      logic        mem_req;
      logic        mem_ack;
      logic        jump_req;
      logic [31:0] jaddr;
      logic [5:0]  exp_stall;
      logic        exp_flush;
      logic [31:0] exp_jaddr;
      logic        exp_start;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(logic load, logic [4:0] rd, logic [4:0] rs1,
                               logic [4:0] rs2, logic re1, logic re2,
                               logic div_req, logic div_ready, logic mem_req,
                               logic mem_ack, logic jump_req, logic [31:0] jaddr,
                               logic [5:0] exp_stall, logic exp_flush,
                               logic [31:0] exp_jaddr, logic exp_start);
      vec_t v;
      v.load = load; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.re1 = re1; v.re2 = re2; v.div_req = div_req; v.div_ready = div_ready;
      v.mem_req = mem_req; v.mem_ack = mem_ack; v.jump_req = jump_req;
      v.jaddr = jaddr; v.exp_stall = exp_stall; v.exp_flush = exp_flush;
      v.exp_jaddr = exp_jaddr; v.exp_start = exp_start;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      pif.ex_inst_is_load_i = v.load;
      pif.ex_rd_i           = v.rd;
      pif.id_rs1_i          = v.rs1;
      pif.id_rs2_i          = v.rs2;
      pif.id_rs1_re_i       = v.re1;
      pif.id_rs2_re_i       = v.re2;
      pif.div_req_i         = v.div_req;
      pif.div_ready_i       = v.div_ready;
      pif.mem_req_i         = v.mem_req;
      pif.mem_ack_i         = v.mem_ack;
      pif.jump_req_i        = v.jump_req;
      pif.jump_addr_i       = v.jaddr;
   endtask

   task automatic driveIdle();
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'b0, 0, 32'h0, 0));
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, " cnt_stall"}, pif.cnt_stall_o, 32'(exp_stall_cnt));
      checkOutput({tag, " cnt_flush"}, pif.cnt_flush_o, 32'(exp_flush_cnt));
   endtask

   initial begin
      passed = 0;
      total  = 0;
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;

      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
      vecs[1]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        6'b000111, 0, 32'h0,        0);
      vecs[2]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
      vecs[3]  = mk(1, 7, 3, 7, 1, 1, 0, 0, 0, 0, 0, 32'h0,        6'b000111, 0, 32'h0,        0);
      vecs[4]  = mk(1, 7, 3, 7, 1, 0, 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
      vecs[5]  = mk(0, 7, 7, 7, 1, 1, 0, 0, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
      vecs[6]  = mk(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 1, 32'h80000040, 6'b000000, 1, 32'h80000040, 0);
      vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h00001234, 6'b000000, 1, 32'h00001234, 0);
      vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
      vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,        6'b000000, 0, 32'h0,        0);
      vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hdeadbeef, 6'b000000, 0, 32'h0,        0);
      vecs[11] = mk(1, 9, 9, 0, 1, 0, 0, 0, 1, 1, 0, 32'h0,        6'b000111, 0, 32'h0,        0);
      vecs[12] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 32'h00000100, 6'b000000, 1, 32'h00000100, 0);

      // Reset state: outputs forced low even with a jump request present.
      rst = 1'b1;
      driveIdle();
      pif.jump_req_i  = 1'b1;
      pif.jump_addr_i = 32'h55aa55aa;
      #3;
      checkOutput("reset jump_o", 32'(pif.jump_o), 32'h0);
      checkOutput("reset jump_addr", pif.jump_addr_o, 32'h0);
      checkOutput("reset stall", 32'(pif.stall_o), 32'h0);
      checkOutput("reset bus_err", 32'(pif.bus_err_o), 32'h0);
      checkCounters("reset");
      @(negedge clk);
      driveIdle();
      @(negedge clk);
      rst = 1'b0;

      // Single-cycle decode table, all in RUN.
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d stall", i), 32'(pif.stall_o), 32'(vecs[i].exp_stall));
         checkOutput($sformatf("vec%0d flush", i), 32'(pif.flush_jump_o), 32'(vecs[i].exp_flush));
         checkOutput($sformatf("vec%0d jump", i), 32'(pif.jump_o), 32'(vecs[i].exp_flush));
         checkOutput($sformatf("vec%0d jaddr", i), pif.jump_addr_o, vecs[i].exp_jaddr);
         checkOutput($sformatf("vec%0d start", i), 32'(pif.div_start_o), 32'(vecs[i].exp_start));
         if (vecs[i].exp_stall[0]) exp_stall_cnt++;
         if (vecs[i].exp_flush) exp_flush_cnt++;
      end
      @(negedge clk);
      driveIdle();
      #1;
      checkCounters("table");

      // Divide: ready arrives 8 cycles after the start cycle. A jump
      // raised mid-wait must be ignored.
      @(negedge clk);
      pif.div_req_i = 1'b1;
      #1;
      checkOutput("div start stall", 32'(pif.stall_o), 32'b001111);
      checkOutput("div start pulse", 32'(pif.div_start_o), 32'h1);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         pif.jump_req_i = (k == 3);
         #1;
         checkOutput($sformatf("div wait%0d stall", k), 32'(pif.stall_o), 32'b001111);
         checkOutput($sformatf("div wait%0d start", k), 32'(pif.div_start_o), 32'h0);
         checkOutput($sformatf("div wait%0d jump", k), 32'(pif.jump_o), 32'h0);
      end
      @(negedge clk);
      pif.jump_req_i  = 1'b0;
      pif.div_ready_i = 1'b1;
      #1;
      checkOutput("div ready stall", 32'(pif.stall_o), 32'h0);
      checkOutput("div ready start", 32'(pif.div_start_o), 32'h0);
      exp_stall_cnt += 8;
      @(negedge clk);
      driveIdle();
      #1;
      checkOutput("div after stall", 32'(pif.stall_o), 32'h0);
      checkCounters("div");

      // Bus timeout: 17 stalled cycles, then bus_err with the stall masked.
      @(negedge clk);
      pif.mem_req_i = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checkOutput($sformatf("tmo cyc%0d stall", i), 32'(pif.stall_o), 32'b011111);
         checkOutput($sformatf("tmo cyc%0d err", i), 32'(pif.bus_err_o), 32'h0);
      end
      @(negedge clk);
      #1;
      checkOutput("tmo err pulse", 32'(pif.bus_err_o), 32'h1);
      checkOutput("tmo err stall", 32'(pif.stall_o), 32'h0);
      exp_stall_cnt += 17;
      @(negedge clk);
      driveIdle();
      #1;
      checkOutput("tmo err cleared", 32'(pif.bus_err_o), 32'h0);
      checkCounters("tmo");

      // Bus wait beats divide; the divide starts the cycle after the ack.
      @(negedge clk);
      pif.mem_req_i = 1'b1;
      pif.div_req_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         #1;
         checkOutput($sformatf("prio cyc%0d stall", i), 32'(pif.stall_o), 32'b011111);
         checkOutput($sformatf("prio cyc%0d start", i), 32'(pif.div_start_o), 32'h0);
      end
      @(negedge clk);
      pif.mem_ack_i = 1'b1;
      #1;
      checkOutput("prio ack stall", 32'(pif.stall_o), 32'h0);
      checkOutput("prio ack start", 32'(pif.div_start_o), 32'h0);
      @(negedge clk);
      pif.mem_req_i = 1'b0;
      pif.mem_ack_i = 1'b0;
      #1;
      checkOutput("prio div stall", 32'(pif.stall_o), 32'b001111);
      checkOutput("prio div start", 32'(pif.div_start_o), 32'h1);
      @(negedge clk);
      pif.div_ready_i = 1'b1;
      #1;
      checkOutput("prio ready stall", 32'(pif.stall_o), 32'h0);
      exp_stall_cnt += 4;
      @(negedge clk);
      driveIdle();
      #1;
      checkCounters("prio");

      // Reset in the middle of a divide wait.
      @(negedge clk);
      pif.div_req_i = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("rstdiv wait stall", 32'(pif.stall_o), 32'b001111);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rstdiv stall", 32'(pif.stall_o), 32'h0);
      checkOutput("rstdiv start", 32'(pif.div_start_o), 32'h0);
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
      checkCounters("rstdiv");
      @(negedge clk);
      pif.div_req_i = 1'b0;
      rst = 1'b0;
      #1;
      checkOutput("rstdiv release stall", 32'(pif.stall_o), 32'h0);
      checkOutput("rstdiv release start", 32'(pif.div_start_o), 32'h0);
      @(negedge clk);
      pif.div_req_i = 1'b1;
      #1;
      checkOutput("rstdiv restart", 32'(pif.div_start_o), 32'h1);
      @(negedge clk);
      pif.div_ready_i = 1'b1;
      #1;
      checkOutput("rstdiv ready stall", 32'(pif.stall_o), 32'h0);
      @(negedge clk);
      driveIdle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
